// File: rtl/baw_pkg.sv
// Black-and-White game controller shared encodings.
// FSM state codes and round/game result codes.
package baw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ROUND_SHOW = 3'd1,
      ST_LEAD_SEL   = 3'd2,
      ST_FOLLOW_SEL = 3'd3,
      ST_RESULT     = 3'd4,
      ST_GAME_OVER  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_P1   = 2'b01,
      RES_P2   = 2'b10,
      RES_TIE  = 2'b11
   } res_e;

   // Bit positions inside the sampled button vector.
   localparam int BTN_START   = 0;
   localparam int BTN_NEXT    = 1;
   localparam int BTN_CONFIRM = 2;
   localparam int BTN_ABORT   = 3;

endpackage

// File: rtl/baw_game_ctrl_if.sv
// Button/switch inputs and display/LED outputs of the game controller.
// master drives the buttons, slave is the controller.
interface baw_game_ctrl_if #(
   parameter int NUM_CARDS = 9,
   parameter int CNT_W     = $clog2(NUM_CARDS + 1)
);

   logic                 btn_start;
   logic                 btn_confirm;
   logic                 btn_next;
   logic                 btn_abort;
   logic [NUM_CARDS-1:0] sel;
   logic [2:0]           state;
   logic                 leader;
   logic [NUM_CARDS-1:0] p1_hand;
   logic [NUM_CARDS-1:0] p2_hand;
   logic [CNT_W-1:0]     p1_black;
   logic [CNT_W-1:0]     p1_white;
   logic [CNT_W-1:0]     p2_black;
   logic [CNT_W-1:0]     p2_white;
   logic                 lead_is_black;
   logic [CNT_W-1:0]     round;
   logic [CNT_W-1:0]     p1_score;
   logic [CNT_W-1:0]     p2_score;
   logic [1:0]           match_result;
   logic [1:0]           game_result;
   logic                 sel_err;

   modport master (
      output btn_start, btn_confirm, btn_next, btn_abort, sel,
      input  state, leader, p1_hand, p2_hand,
      input  p1_black, p1_white, p2_black, p2_white,
      input  lead_is_black, round, p1_score, p2_score,
      input  match_result, game_result, sel_err
   );

   modport slave (
      input  btn_start, btn_confirm, btn_next, btn_abort, sel,
      output state, leader, p1_hand, p2_hand,
      output p1_black, p1_white, p2_black, p2_white,
      output lead_is_black, round, p1_score, p2_score,
      output match_result, game_result, sel_err
   );

endinterface

// File: rtl/baw_hand.sv
// One player's hand: remaining-card mask, selection check,
// card encoder and black (odd) / white (even) popcounts.
module baw_hand #(
   parameter int NUM_CARDS = 9,
   parameter int CARD_W    = $clog2(NUM_CARDS),
   parameter int CNT_W     = $clog2(NUM_CARDS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clr,
   input  logic                 i_play,
   input  logic [NUM_CARDS-1:0] i_sel,
   output logic [NUM_CARDS-1:0] o_hand,
   output logic                 o_valid,
   output logic [CARD_W-1:0]    o_card,
   output logic [CNT_W-1:0]     o_black,
   output logic [CNT_W-1:0]     o_white
);

   logic [NUM_CARDS-1:0] r_hand;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_hand <= '1;
      else if (i_clr)
         r_hand <= '1;
      else if (i_play)
         r_hand <= r_hand & ~i_sel;
   end

   assign o_hand  = r_hand;
   assign o_valid = $onehot(i_sel) && (|(i_sel & r_hand));

   always_comb begin
      o_card = '0;
      for (int i = 0; i < NUM_CARDS; i++)
         if (i_sel[i]) o_card = CARD_W'(i);
   end

   always_comb begin
      o_black = '0;
      o_white = '0;
      for (int i = 0; i < NUM_CARDS; i++) begin
         if (r_hand[i]) begin
            if (i % 2 == 1) o_black = o_black + CNT_W'(1);
            else            o_white = o_white + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/baw_game_ctrl.sv
// Black-and-White game controller: button edge detection, round FSM,
// scoring and finish detection over two baw_hand instances.
module baw_game_ctrl
   import baw_pkg::*;
#(
   parameter int NUM_CARDS  = 9,
   parameter int CARD_W     = $clog2(NUM_CARDS),
   parameter int CNT_W      = $clog2(NUM_CARDS + 1),
   parameter int WIN_TARGET = NUM_CARDS / 2 + 1
) (
   input logic            clk,
   input logic            rst,
   baw_game_ctrl_if.slave bus
);

   logic [3:0]           r_btn, r_btn_q, w_edge;
   logic                 w_abort, w_confirm, w_next, w_start;
   state_e               r_state;
   res_e                 r_mr, r_gr;
   logic                 r_leader, r_lib, r_err;
   logic [CARD_W-1:0]    r_lead_card;
   logic [CNT_W-1:0]     r_round, r_s1, r_s2;
   logic [NUM_CARDS-1:0] w_h1, w_h2;
   logic                 w_v1, w_v2, w_valid, w_p2_act;
   logic [CARD_W-1:0]    w_c1, w_c2, w_card, w_p1c, w_p2c;
   logic [CNT_W-1:0]     w_b1, w_w1, w_b2, w_w2;
   logic                 w_try, w_play, w_play1, w_play2, w_clr;
   logic [CNT_W-1:0]     w_rnd_inc, w_s1_inc, w_s2_inc;
   logic [CNT_W-1:0]     w_diff, w_left;
   logic                 w_done;

   // Held-through-reset buttons must not fire, so both stages load 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn   <= '1;
         r_btn_q <= '1;
      end else begin
         r_btn   <= {bus.btn_abort, bus.btn_confirm,
                     bus.btn_next, bus.btn_start};
         r_btn_q <= r_btn;
      end
   end

   assign w_edge    = r_btn & ~r_btn_q;
   assign w_abort   = w_edge[BTN_ABORT];
   assign w_confirm = w_edge[BTN_CONFIRM] & ~w_abort;
   assign w_next    = w_edge[BTN_NEXT] & ~w_abort & ~w_edge[BTN_CONFIRM];
   assign w_start   = w_edge[BTN_START] & ~w_abort
                    & ~w_edge[BTN_CONFIRM] & ~w_edge[BTN_NEXT];

   assign w_p2_act = (r_state == ST_LEAD_SEL) ? r_leader : ~r_leader;
   assign w_valid  = w_p2_act ? w_v2 : w_v1;
   assign w_card   = w_p2_act ? w_c2 : w_c1;
   assign w_try    = w_confirm & ((r_state == ST_LEAD_SEL) |
                                  (r_state == ST_FOLLOW_SEL));
   assign w_play   = w_try & w_valid;
   assign w_play1  = w_play & ~w_p2_act;
   assign w_play2  = w_play & w_p2_act;
   assign w_clr    = w_abort | (w_start & ((r_state == ST_IDLE) |
                                           (r_state == ST_GAME_OVER)));

   assign w_p1c = r_leader ? w_card : r_lead_card;
   assign w_p2c = r_leader ? r_lead_card : w_card;

   assign w_rnd_inc = (r_round == CNT_W'(NUM_CARDS)) ? r_round : r_round + CNT_W'(1);
   assign w_s1_inc  = (r_s1 == CNT_W'(NUM_CARDS)) ? r_s1 : r_s1 + CNT_W'(1);
   assign w_s2_inc  = (r_s2 == CNT_W'(NUM_CARDS)) ? r_s2 : r_s2 + CNT_W'(1);

   // Early decision: the trailing player cannot catch up any more.
   assign w_diff = (r_s1 > r_s2) ? r_s1 - r_s2 : r_s2 - r_s1;
   assign w_left = CNT_W'(NUM_CARDS) - r_round;
   assign w_done = (r_s1 == CNT_W'(WIN_TARGET)) | (r_s2 == CNT_W'(WIN_TARGET)) |
                   (r_round == CNT_W'(NUM_CARDS)) | (w_diff > w_left);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_leader    <= 1'b0;
         r_lib       <= 1'b0;
         r_lead_card <= '0;
         r_round     <= '0;
         r_s1        <= '0;
         r_s2        <= '0;
         r_mr        <= RES_NONE;
         r_gr        <= RES_NONE;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_try & ~w_valid;
         if (w_clr) begin
            r_leader <= 1'b0;
            r_round  <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_mr     <= RES_NONE;
            r_gr     <= RES_NONE;
         end
         if (w_abort) begin
            r_state <= ST_IDLE;
         end else begin
            unique case (r_state)
               ST_IDLE:
                  if (w_start) r_state <= ST_ROUND_SHOW;
               ST_ROUND_SHOW:
                  if (w_next) r_state <= ST_LEAD_SEL;
               ST_LEAD_SEL:
                  if (w_play) begin
                     r_state     <= ST_FOLLOW_SEL;
                     r_lead_card <= w_card;
                     r_lib       <= w_card[0];
                  end
               ST_FOLLOW_SEL:
                  if (w_play) begin
                     r_state <= ST_RESULT;
                     r_round <= w_rnd_inc;
                     if (w_p1c > w_p2c) begin
                        r_s1 <= w_s1_inc;
                        r_mr <= RES_P1;
                     end else if (w_p1c < w_p2c) begin
                        r_s2 <= w_s2_inc;
                        r_mr <= RES_P2;
                     end else begin
                        r_mr <= RES_TIE;
                     end
                  end
               ST_RESULT:
                  if (w_confirm) begin
                     r_mr <= RES_NONE;
                     if (r_mr == RES_P1) r_leader <= 1'b0;
                     if (r_mr == RES_P2) r_leader <= 1'b1;
                     if (w_done) begin
                        r_state <= ST_GAME_OVER;
                        r_gr    <= (r_s1 > r_s2) ? RES_P1 :
                                   (r_s1 < r_s2) ? RES_P2 : RES_TIE;
                     end else begin
                        r_state <= ST_ROUND_SHOW;
                     end
                  end
               ST_GAME_OVER:
                  if (w_start) r_state <= ST_IDLE;
               default:
                  r_state <= ST_IDLE;
            endcase
         end
      end
   end

   baw_hand #(.NUM_CARDS(NUM_CARDS), .CARD_W(CARD_W), .CNT_W(CNT_W)) u_p1 (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_play(w_play1), .i_sel(bus.sel),
      .o_hand(w_h1), .o_valid(w_v1), .o_card(w_c1),
      .o_black(w_b1), .o_white(w_w1)
   );

   baw_hand #(.NUM_CARDS(NUM_CARDS), .CARD_W(CARD_W), .CNT_W(CNT_W)) u_p2 (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_play(w_play2), .i_sel(bus.sel),
      .o_hand(w_h2), .o_valid(w_v2), .o_card(w_c2),
      .o_black(w_b2), .o_white(w_w2)
   );

   assign bus.state         = r_state;
   assign bus.leader        = r_leader;
   assign bus.p1_hand       = w_h1;
   assign bus.p2_hand       = w_h2;
   assign bus.p1_black      = w_b1;
   assign bus.p1_white      = w_w1;
   assign bus.p2_black      = w_b2;
   assign bus.p2_white      = w_w2;
   assign bus.lead_is_black = r_lib;
   assign bus.round         = r_round;
   assign bus.p1_score      = r_s1;
   assign bus.p2_score      = r_s2;
   assign bus.match_result  = r_mr;
   assign bus.game_result   = r_gr;
   assign bus.sel_err       = r_err;

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Bench for baw_game_ctrl: directed vector table, hand-written game
// sequences, and a random walk checked against a rule-level game model.
module tb_baw_game_ctrl;
   import baw_pkg::*;

   localparam int N  = 9;
   localparam int WT = N / 2 + 1;
   localparam int N3 = 3;
   localparam int BS = 0, BN = 1, BC = 2, BA = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   baw_game_ctrl_if #(.NUM_CARDS(N))  bus ();
   baw_game_ctrl_if #(.NUM_CARDS(N3)) bus3 ();

   baw_game_ctrl #(.NUM_CARDS(N))  dut  (.clk(clk), .rst(rst), .bus(bus));
   baw_game_ctrl #(.NUM_CARDS(N3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0] cd(input int v);
      logic [N-1:0] m;
      m = '0;
      m[v] = 1'b1;
      return m;
   endfunction

   function automatic int nodd(input logic [N-1:0] h, input int odd);
      int c;
      c = 0;
      for (int i = 0; i < N; i++)
         if (h[i] && (i % 2 == odd)) c++;
      return c;
   endfunction

   task automatic set_btn(input int b, input logic v);
      case (b)
         BS: bus.btn_start   = v;
         BN: bus.btn_next    = v;
         BC: bus.btn_confirm = v;
         default: bus.btn_abort = v;
      endcase
   endtask

   task automatic press(input int b, input logic [N-1:0] s, output int errs);
      errs = 0;
      @(negedge clk);
      bus.sel = s;
      set_btn(b, 1'b1);
      repeat (3) begin @(negedge clk); errs += int'(bus.sel_err); end
      set_btn(b, 1'b0);
      repeat (2) begin @(negedge clk); errs += int'(bus.sel_err); end
   endtask

   task automatic set_btn3(input int b, input logic v);
      case (b)
         BS: bus3.btn_start   = v;
         BN: bus3.btn_next    = v;
         BC: bus3.btn_confirm = v;
         default: bus3.btn_abort = v;
      endcase
   endtask

   task automatic press3(input int b, input logic [N3-1:0] s);
      @(negedge clk);
      bus3.sel = s;
      set_btn3(b, 1'b1);
      repeat (3) @(negedge clk);
      set_btn3(b, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   // ---------------- rule-level reference model ----------------
   int m_st, m_ldr, m_rnd, m_mr, m_gr, m_lc, m_lib;
   int m_s[2];
   bit m_h[2][N];

   task automatic m_clear();
      m_ldr = 0; m_rnd = 0; m_mr = 0; m_gr = 0;
      m_s[0] = 0; m_s[1] = 0;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) m_h[p][i] = 1'b1;
   endtask

   function automatic logic [N-1:0] m_mask(input int p);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = m_h[p][i];
      return m;
   endfunction

   task automatic m_step(input int b, input logic [N-1:0] s, output int exp_err);
      int a, cnt, idx, p1c, p2c, diff;
      exp_err = 0;
      if (b == BA) begin
         m_st = 0; m_clear();
         return;
      end
      case (m_st)
         0: if (b == BS) begin m_clear(); m_st = 1; end
         1: if (b == BN) m_st = 2;
         2, 3: if (b == BC) begin
            a = (m_st == 2) ? m_ldr : 1 - m_ldr;
            cnt = 0; idx = 0;
            for (int i = 0; i < N; i++) if (s[i]) begin cnt++; idx = i; end
            if (cnt == 1 && m_h[a][idx]) begin
               m_h[a][idx] = 1'b0;
               if (m_st == 2) begin
                  m_lc = idx; m_lib = idx % 2; m_st = 3;
               end else begin
                  p1c = (m_ldr == 0) ? m_lc : idx;
                  p2c = (m_ldr == 0) ? idx : m_lc;
                  if (p1c > p2c)      begin m_mr = 1; m_s[0]++; end
                  else if (p1c < p2c) begin m_mr = 2; m_s[1]++; end
                  else m_mr = 3;
                  m_rnd++;
                  m_st = 4;
               end
            end else exp_err = 1;
         end
         4: if (b == BC) begin
            if (m_mr == 1) m_ldr = 0;
            if (m_mr == 2) m_ldr = 1;
            m_mr = 0;
            diff = m_s[0] - m_s[1];
            if (diff < 0) diff = -diff;
            if (m_s[0] == WT || m_s[1] == WT || m_rnd == N || diff > N - m_rnd) begin
               m_st = 5;
               m_gr = (m_s[0] > m_s[1]) ? 1 : (m_s[0] < m_s[1]) ? 2 : 3;
            end else m_st = 1;
         end
         default: if (b == BS) begin m_st = 0; m_clear(); end
      endcase
   endtask

   task automatic check_model(input int errs, input int exp_err);
      logic [N-1:0] h1, h2;
      h1 = m_mask(0);
      h2 = m_mask(1);
      chk("rnd.state", bus.state, m_st);
      chk("rnd.leader", bus.leader, m_ldr);
      chk("rnd.p1_hand", bus.p1_hand, h1);
      chk("rnd.p2_hand", bus.p2_hand, h2);
      chk("rnd.p1_black", bus.p1_black, nodd(h1, 1));
      chk("rnd.p1_white", bus.p1_white, nodd(h1, 0));
      chk("rnd.p2_black", bus.p2_black, nodd(h2, 1));
      chk("rnd.p2_white", bus.p2_white, nodd(h2, 0));
      chk("rnd.round", bus.round, m_rnd);
      chk("rnd.p1_score", bus.p1_score, m_s[0]);
      chk("rnd.p2_score", bus.p2_score, m_s[1]);
      chk("rnd.match", bus.match_result, m_mr);
      chk("rnd.game", bus.game_result, m_gr);
      chk("rnd.sel_err", errs, exp_err);
      if (m_st == 3 || m_st == 4) chk("rnd.lib", bus.lead_is_black, m_lib);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int           b;
      logic [N-1:0] s;
      int           st, err, mr, p1s, p2s, rnd, ldr, lib;
      logic [N-1:0] h1, h2;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int errs, exp_err, r, b, a;
      logic [N-1:0] s;
      int q[$];

      tbl[0]  = '{BS, '0,      1, 0, 0, 0, 0, 0, 0, 0, 9'h1FF, 9'h1FF};
      tbl[1]  = '{BN, '0,      2, 0, 0, 0, 0, 0, 0, 0, 9'h1FF, 9'h1FF};
      tbl[2]  = '{BC, 9'h003,  2, 1, 0, 0, 0, 0, 0, 0, 9'h1FF, 9'h1FF};
      tbl[3]  = '{BC, cd(7),   3, 0, 0, 0, 0, 0, 0, 1, 9'h17F, 9'h1FF};
      tbl[4]  = '{BC, cd(3),   4, 0, 1, 1, 0, 1, 0, 1, 9'h17F, 9'h1F7};
      tbl[5]  = '{BC, '0,      1, 0, 0, 1, 0, 1, 0, 0, 9'h17F, 9'h1F7};
      tbl[6]  = '{BN, '0,      2, 0, 0, 1, 0, 1, 0, 0, 9'h17F, 9'h1F7};
      tbl[7]  = '{BC, cd(7),   2, 1, 0, 1, 0, 1, 0, 0, 9'h17F, 9'h1F7};
      tbl[8]  = '{BC, cd(4),   3, 0, 0, 1, 0, 1, 0, 0, 9'h16F, 9'h1F7};
      tbl[9]  = '{BC, cd(4),   4, 0, 3, 1, 0, 2, 0, 0, 9'h16F, 9'h1E7};
      tbl[10] = '{BC, '0,      1, 0, 0, 1, 0, 2, 0, 0, 9'h16F, 9'h1E7};
      tbl[11] = '{BN, '0,      2, 0, 0, 1, 0, 2, 0, 0, 9'h16F, 9'h1E7};
      tbl[12] = '{BC, cd(0),   3, 0, 0, 1, 0, 2, 0, 0, 9'h16E, 9'h1E7};
      tbl[13] = '{BC, cd(8),   4, 0, 2, 1, 1, 3, 0, 0, 9'h16E, 9'h0E7};
      tbl[14] = '{BC, '0,      1, 0, 0, 1, 1, 3, 1, 0, 9'h16E, 9'h0E7};
      tbl[15] = '{BA, '0,      0, 0, 0, 0, 0, 0, 0, 0, 9'h1FF, 9'h1FF};

      bus.btn_start = 1'b1;
      bus.btn_next = 1'b0; bus.btn_confirm = 1'b0; bus.btn_abort = 1'b0;
      bus.sel = '0;
      bus3.btn_start = 1'b0; bus3.btn_next = 1'b0;
      bus3.btn_confirm = 1'b0; bus3.btn_abort = 1'b0;
      bus3.sel = '0;

      // reset with start held: nothing may fire
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst.state", bus.state, 0);
      chk("rst.leader", bus.leader, 0);
      chk("rst.p1_hand", bus.p1_hand, 9'h1FF);
      chk("rst.p2_hand", bus.p2_hand, 9'h1FF);
      chk("rst.p1_black", bus.p1_black, 4);
      chk("rst.p1_white", bus.p1_white, 5);
      chk("rst.round", bus.round, 0);
      chk("rst.scores", {bus.p1_score, bus.p2_score}, 0);
      chk("rst.results", {bus.match_result, bus.game_result}, 0);
      chk("rst.sel_err", bus.sel_err, 0);
      chk("rst.lib", bus.lead_is_black, 0);
      chk("rst3.state", bus3.state, 0);
      chk("rst3.p1_black", bus3.p1_black, 1);
      chk("rst3.p1_white", bus3.p1_white, 2);
      bus.btn_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("release.state", bus.state, 0);

      for (int i = 0; i < 16; i++) begin
         press(tbl[i].b, tbl[i].s, errs);
         chk($sformatf("v%0d.state", i), bus.state, tbl[i].st);
         chk($sformatf("v%0d.sel_err", i), errs, tbl[i].err);
         chk($sformatf("v%0d.match", i), bus.match_result, tbl[i].mr);
         chk($sformatf("v%0d.p1_score", i), bus.p1_score, tbl[i].p1s);
         chk($sformatf("v%0d.p2_score", i), bus.p2_score, tbl[i].p2s);
         chk($sformatf("v%0d.round", i), bus.round, tbl[i].rnd);
         chk($sformatf("v%0d.leader", i), bus.leader, tbl[i].ldr);
         chk($sformatf("v%0d.p1_hand", i), bus.p1_hand, tbl[i].h1);
         chk($sformatf("v%0d.p2_hand", i), bus.p2_hand, tbl[i].h2);
         chk($sformatf("v%0d.p1_black", i), bus.p1_black, nodd(tbl[i].h1, 1));
         chk($sformatf("v%0d.p2_white", i), bus.p2_white, nodd(tbl[i].h2, 0));
         chk($sformatf("v%0d.game", i), bus.game_result, 0);
         if (tbl[i].st == 3 || tbl[i].st == 4)
            chk($sformatf("v%0d.lib", i), bus.lead_is_black, tbl[i].lib);
      end

      // P1 takes five straight rounds: decided after the fifth
      press(BS, '0, errs);
      for (int k = 0; k < 5; k++) begin
         press(BN, '0, errs);
         press(BC, cd(k + 1), errs);
         press(BC, cd(k), errs);
         chk($sformatf("win%0d.match", k), bus.match_result, 1);
         press(BC, '0, errs);
         chk($sformatf("win%0d.state", k), bus.state, (k == 4) ? 5 : 1);
      end
      chk("win.game", bus.game_result, 1);
      chk("win.p1_score", bus.p1_score, 5);
      chk("win.round", bus.round, 5);
      press(BC, '0, errs);
      chk("over.hold", bus.state, 5);
      chk("over.game_hold", bus.game_result, 1);
      press(BS, '0, errs);
      chk("over.idle", bus.state, 0);
      chk("over.game_clr", bus.game_result, 0);

      // abort in the middle of a round
      press(BS, '0, errs);
      press(BN, '0, errs);
      press(BC, cd(5), errs);
      chk("abort.pre", bus.state, 3);
      press(BA, '0, errs);
      chk("abort.state", bus.state, 0);
      chk("abort.p1_score", bus.p1_score, 0);
      chk("abort.p1_hand", bus.p1_hand, 9'h1FF);
      chk("abort.p2_hand", bus.p2_hand, 9'h1FF);

      // random walk against the game model
      m_st = 0;
      m_clear();
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3)       b = BA;
         else if (r < 10) b = $urandom_range(0, 2);
         else case (m_st)
            0, 5:    b = BS;
            1:       b = BN;
            default: b = BC;
         endcase
         s = N'($urandom);
         if (b == BC && (m_st == 2 || m_st == 3) && $urandom_range(0, 99) < 85) begin
            a = (m_st == 2) ? m_ldr : 1 - m_ldr;
            q.delete();
            for (int i = 0; i < N; i++) if (m_h[a][i]) q.push_back(i);
            if (q.size() > 0) s = cd(q[$urandom_range(0, q.size() - 1)]);
         end
         press(b, s, errs);
         m_step(b, s, exp_err);
         check_model(errs, exp_err);
      end

      // three-card game of all ties ends in a draw
      press3(BS, '0);
      for (int k = 0; k < 3; k++) begin
         press3(BN, '0);
         press3(BC, 3'(1 << k));
         press3(BC, 3'(1 << k));
         chk($sformatf("n3.tie%0d", k), bus3.match_result, 3);
         press3(BC, '0);
         chk($sformatf("n3.state%0d", k), bus3.state, (k == 2) ? 5 : 1);
      end
      chk("n3.round", bus3.round, 3);
      chk("n3.game", bus3.game_result, 3);
      chk("n3.scores", {bus3.p1_score, bus3.p2_score}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
